object_transform: RTL
=====================

// Module: object_transform
// PURPOSE
//  Downstream of the global-register loader. While STATUS=1 and FINISH=0, reads
//  3-byte object records (X, Y, COLOR) from the byte stream, rotates each point
//  by Angle and scales it by Zoom about (X_center, Y_center), then emits one
//  pixel to the rasteriser. Pulses NEXT once per completed object so the
//  loader decrements its object count.
// PARAMETERS
//  ZOOM_FRAC   4   fractional bits of Zoom (unsigned Q4.4; 0x10 = 1.0)
//  TRIG_FRAC   7   fractional bits of sin/cos LUT (Q1.7; +128 = +1.0)
// PORTS
//  ACLK       in   1  clock
//  reset      in   1  synchronous, active-high reset
//  STATUS     in   1  1 = object phase (globals valid)
//  FINISH     in   1  1 = no objects remain
//  X_center   in   8  rotation centre X (unsigned)
//  Y_center   in   8  rotation centre Y (unsigned)
//  Angle      in   8  rotation, 256 steps per turn, counter-clockwise
//  Zoom       in   8  scale factor, unsigned Q4.4
//  in_byte    in   8  object record byte
//  in_valid   in   1  in_byte valid
//  in_ready   out  1  block accepts in_byte this cycle
//  pix_x      out  8  transformed X
//  pix_y      out  8  transformed Y
//  pix_color  out  8  object colour, passed through
//  pix_valid  out  1  pixel valid; held until pix_ready
//  pix_ready  in   1  downstream accepts pixel
//  NEXT       out  1  one-cycle pulse per finished object
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, pix_valid, NEXT and busy = 0; pix_x/y/color = 0.
//  Synchronous reset mid-operation drops any partial object; no NEXT is issued.
//  States: IDLE, LD_X, LD_Y, LD_C, ROT, SCL, OUT, WAIT.
//  - IDLE: go to LD_X when STATUS & ~FINISH, else stay.
//  - LD_X/LD_Y/LD_C: in_ready=1; advance only on in_valid&in_ready.
//    On the LD_X handshake, latch Angle, Zoom, X_center and Y_center so they
//    are stable for the whole object.
//  - ROT: dx=X-Xc, dy=Y-Yc (9-bit signed). Register
//    rx=(dx*cos-dy*sin)>>>7 and ry=(dx*sin+dy*cos)>>>7 (19-bit signed;
//    arithmetic shift, floor).
//  - SCL: sx=(rx*Zoom)>>>4, sy=(ry*Zoom)>>>4. Take X'=Xc+sx and Y'=Yc+sy in
//    signed arithmetic wide enough that nothing wraps. Set oor=1 if X' or Y'
//    lies outside 0..255. Register the result.
//  - OUT: pix_valid=1, with outputs stable until pix_ready. On the handshake,
//    pulse NEXT in the following cycle and go to WAIT.
//  - WAIT: one cycle for the loader's FINISH to update. Then go to LD_X if
//    STATUS & ~FINISH, else IDLE.
//  - LUT: sin[k]=round(128*sin(2*pi*k/256)) and cos[k]=sin[(k+64) mod 256].
//    Built from a 65-entry quarter wave; values span -128..+128 (9-bit signed).
//  - Latency: 3 cycles from the LD_C handshake to pix_valid=1.
//  - Throughput: at most 1 object per 8 cycles.
//  - STATUS dropping mid-object does not abort the object. It is only sampled
//    in IDLE and WAIT.
//  - in_valid is ignored outside the LD_* states, and in_ready is 0 there.
//  - pix_ready may already be high when pix_valid rises; the handshake then
//    completes in the first OUT cycle.
// CONFIGURATION
//  SATURATE_EN defined: out-of-range X'/Y' are clamped to 0 or 255 and the
//    pixel is emitted.
//  SATURATE_EN undefined: if oor=1, skip OUT (pix_valid stays 0), pulse NEXT
//    directly after SCL, then enter WAIT.
// TESTING
//  T1 identity: Xc=Yc=100, Angle=0, Zoom=0x10, record (120,90,0x3C)
//     -> pix=(120,90,0x3C), NEXT pulses once.
//  T2 90 deg: Xc=Yc=100, Angle=64, Zoom=0x10, record (110,100)
//     -> pix=(100,110); record (100,110) -> pix=(90,100).
//  T3 zoom: Xc=Yc=50, Angle=0, Zoom=0x20, record (60,45) -> pix=(70,40);
//     Zoom=0x08, record (60,45) -> pix=(55,47).
//  T4 range: Xc=Yc=128, Angle=0, Zoom=0x20, record (255,128)
//     -> SATURATE_EN: pix=(255,128); without: no pix_valid, NEXT still pulses.
//  T5 backpressure/stall: hold pix_ready=0 for 5 cycles and gap in_valid
//     between bytes -> pixel held stable, one NEXT only after the handshake,
//     no byte lost or duplicated.
//  T6 sequencing/reset: loader count=2 -> exactly 2 NEXT pulses, then IDLE
//     once FINISH=1; reset asserted during ROT -> all outputs 0 next cycle,
//     no NEXT.

Source files
------------

// File: rtl/object_transform.sv
// rtl/object_transform.sv - rotates and zooms object points about a centre and emits one pixel per object
// Build macro SATURATE_EN: clamp out-of-range pixels instead of dropping them.
module object_transform #(
  parameter int ZOOM_FRAC = 4,
  parameter int TRIG_FRAC = 7
) (
  input  logic       ACLK,
  input  logic       reset,
  input  logic       STATUS,
  input  logic       FINISH,
  input  logic [7:0] X_center,
  input  logic [7:0] Y_center,
  input  logic [7:0] Angle,
  input  logic [7:0] Zoom,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic [7:0] pix_color,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       NEXT,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LD_X, LD_Y, LD_C, ROT, SCL, OUT, WAIT} state_t;

`ifdef SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // round(128*sin(2*pi*i/256)) for i = 0..64
  localparam logic [7:0] QSIN [0:64] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd13,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd52,  8'd55,  8'd58,  8'd60,  8'd63,  8'd66,  8'd68,
    8'd71,  8'd74,  8'd76,  8'd79,  8'd81,  8'd84,  8'd86,  8'd88,
    8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
    8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd116, 8'd117,
    8'd118, 8'd119, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124, 8'd125,
    8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd128, 8'd128, 8'd128,
    8'd128
  };

  function automatic logic signed [8:0] sin_lut(input logic [7:0] k);
    logic [6:0]        m;
    logic signed [8:0] mag;
    m   = (k[6:0] > 7'd64) ? 7'(8'd128 - {1'b0, k[6:0]}) : k[6:0];
    mag = $signed({1'b0, QSIN[m]});
    return k[7] ? -mag : mag;
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [29:0] v);
    if (v < 30'sd0)   return 8'd0;
    if (v > 30'sd255) return 8'd255;
    return v[7:0];
  endfunction

  state_t state, state_d;
  logic   next_d;

  logic [7:0] obj_x, obj_y, obj_c;
  logic [7:0] ang_q, zoom_q, xc_q, yc_q;
  logic signed [18:0] rx_q, ry_q;

  // Rotation datapath, consumed in ROT
  logic signed [8:0]  cos_v, sin_v, dx, dy;
  logic signed [18:0] dx_e, dy_e, cos_e, sin_e, rx_sum, ry_sum;

  assign cos_v  = sin_lut(ang_q + 8'd64);
  assign sin_v  = sin_lut(ang_q);
  assign dx     = $signed({1'b0, obj_x}) - $signed({1'b0, xc_q});
  assign dy     = $signed({1'b0, obj_y}) - $signed({1'b0, yc_q});
  assign dx_e   = 19'(dx);
  assign dy_e   = 19'(dy);
  assign cos_e  = 19'(cos_v);
  assign sin_e  = 19'(sin_v);
  assign rx_sum = dx_e * cos_e - dy_e * sin_e;
  assign ry_sum = dx_e * sin_e + dy_e * cos_e;

  // Scale datapath, consumed in SCL; 30 bits so no intermediate can wrap
  logic signed [29:0] zoom_e, sx, sy, xp, yp;
  logic               oor;

  assign zoom_e = $signed({22'd0, zoom_q});
  assign sx     = (30'(rx_q) * zoom_e) >>> ZOOM_FRAC;
  assign sy     = (30'(ry_q) * zoom_e) >>> ZOOM_FRAC;
  assign xp     = $signed({22'd0, xc_q}) + sx;
  assign yp     = $signed({22'd0, yc_q}) + sy;
  assign oor    = (xp < 30'sd0) || (xp > 30'sd255) || (yp < 30'sd0) || (yp > 30'sd255);

  always_comb begin
    state_d = state;
    next_d  = 1'b0;
    case (state)
      IDLE: if (STATUS && !FINISH) state_d = LD_X;
      LD_X: if (in_valid) state_d = LD_Y;
      LD_Y: if (in_valid) state_d = LD_C;
      LD_C: if (in_valid) state_d = ROT;
      ROT:  state_d = SCL;
      SCL: begin
        if (oor && !SATURATE) begin
          state_d = WAIT;
          next_d  = 1'b1;
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (pix_ready) begin
          state_d = WAIT;
          next_d  = 1'b1;
        end
      end
      // NEXT is high in the first WAIT cycle; decide in the second, once the loader's count has moved
      WAIT: if (!NEXT) state_d = (STATUS && !FINISH) ? LD_X : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      state     <= IDLE;
      NEXT      <= 1'b0;
      obj_x     <= 8'd0;
      obj_y     <= 8'd0;
      obj_c     <= 8'd0;
      ang_q     <= 8'd0;
      zoom_q    <= 8'd0;
      xc_q      <= 8'd0;
      yc_q      <= 8'd0;
      rx_q      <= '0;
      ry_q      <= '0;
      pix_x     <= 8'd0;
      pix_y     <= 8'd0;
      pix_color <= 8'd0;
    end else begin
      state <= state_d;
      NEXT  <= next_d;
      case (state)
        LD_X: begin
          if (in_valid) begin
            obj_x  <= in_byte;
            ang_q  <= Angle;
            zoom_q <= Zoom;
            xc_q   <= X_center;
            yc_q   <= Y_center;
          end
        end
        LD_Y: if (in_valid) obj_y <= in_byte;
        LD_C: if (in_valid) obj_c <= in_byte;
        ROT: begin
          rx_q <= rx_sum >>> TRIG_FRAC;
          ry_q <= ry_sum >>> TRIG_FRAC;
        end
        SCL: begin
          pix_x     <= clamp8(xp);
          pix_y     <= clamp8(yp);
          pix_color <= obj_c;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == LD_X) || (state == LD_Y) || (state == LD_C);
  assign pix_valid = (state == OUT);
  assign busy      = (state != IDLE);

endmodule
